// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   Decimal stopwatch that feeds the per-digit seven-segment decoders.
//   A prescaler divides clk down to a count tick. Each tick advances a
//   ripple-carry BCD counter. A rising edge on start_stop toggles between
//   running and stopped, and clear returns everything to zero.
//
// Ports
//   clk         in   1          system clock, rising edge
//   reset       in   1          asynchronous, active-high reset
//   start_stop  in   1          debounced level; each rising edge toggles run/stop
//   clear       in   1          synchronous clear of count, prescaler and overflow
//   digits      out  4*DIGITS   per-digit codes, [3:0] = least significant digit;
//                               0-9, or 4'hF for a blanked leading zero
//   running     out  1          high while the stopwatch is running
//   overflow    out  1          sticky flag, set when the count wraps from all 9s to 0
module bcd_stopwatch #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 500000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  overflow
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  running_q, running_d;
    logic                  prev_ss_q;

    logic                  ss_edge_s;
    logic [4*DIGITS-1:0]   count_inc_s;
    logic                  wrap_s;
    logic                  carry_s;
    logic                  lz_s;
    logic [4*DIGITS-1:0]   digits_s;

    // BCD increment of the registered count; wrap_s flags all 9s rolling to 0.
    always_comb begin
        carry_s     = 1'b1;
        count_inc_s = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc_s[4*i +: 4] = 4'd0;
                end else begin
                    count_inc_s[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry_s               = 1'b0;
                end
            end else begin
                count_inc_s[4*i +: 4] = count_q[4*i +: 4];
            end
        end
        wrap_s = carry_s;
    end

    // Next-state logic: clear beats a start_stop edge, which beats a tick.
    // An edge cycle never advances the prescaler, so the cycle leaving RUN has no tick.
    always_comb begin
        ss_edge_s = start_stop & ~prev_ss_q;
        state_d   = state_q;
        pre_d     = pre_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (clear) begin
            state_d = ST_STOP;
            pre_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (ss_edge_s) begin
            case (state_q)
                ST_STOP: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end else if (state_q == ST_RUN) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                count_d = count_inc_s;
                if (wrap_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end else begin
            pre_d = pre_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // State, prescaler, count and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOP;
            pre_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            prev_ss_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
            prev_ss_q <= start_stop;
        end
    end

    // Leading-zero blanking: scanning from the top, a digit blanks while it and
    // every digit above it are zero. Digit 0 always shows.
    always_comb begin
        lz_s     = 1'b1;
        digits_s = count_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_s = lz_s & (count_q[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && lz_s) begin
                digits_s[4*i +: 4] = 4'hF;
            end else begin
                digits_s[4*i +: 4] = count_q[4*i +: 4];
            end
        end
    end

    assign digits   = digits_s;
    assign running  = running_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
//   Directed scenarios followed by random start_stop/clear activity. Every
//   cycle is compared against an integer-arithmetic model of the stopwatch.
module tb_bcd_stopwatch;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int MODULUS  = 10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_stop;
    logic        clear;
    logic [15:0] digits;
    logic        running;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers.
    int m_cnt;
    int m_pre;
    bit m_run;
    bit m_ovf;
    bit m_prev;

    bcd_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_LZ(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits),
        .running    (running),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Decimal rendering of an integer with leading digits above the highest nonzero one blanked.
    function automatic logic [15:0] exp_digits(input int cnt);
        logic [15:0] r;
        int v;
        int top;
        int d;
        v   = cnt;
        top = 0;
        r   = 16'h0000;
        for (int i = 0; i < DIGITS; i++) begin
            d = v % 10;
            v = v / 10;
            r[4*i +: 4] = 4'(d);
            if (d != 0) top = i;
        end
        for (int i = 1; i < DIGITS; i++) begin
            if (i > top) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_pre  = 0;
        m_run  = 1'b0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic ss, input logic clr);
        bit ss_rise;
        @(negedge clk);
        start_stop = ss;
        clear      = clr;
        @(posedge clk);
        #1;
        ss_rise = ss && !m_prev;
        m_prev  = ss;
        if (clr) begin
            m_cnt = 0;
            m_pre = 0;
            m_ovf = 1'b0;
            m_run = 1'b0;
        end else if (ss_rise) begin
            m_run = !m_run;
        end else if (m_run) begin
            if (m_pre == TICK_DIV - 1) begin
                m_pre = 0;
                m_cnt = m_cnt + 1;
                if (m_cnt == MODULUS) begin
                    m_cnt = 0;
                    m_ovf = 1'b1;
                end
            end else begin
                m_pre++;
            end
        end
        chk("digits",   digits,            exp_digits(m_cnt));
        chk("running",  {15'd0, running},  {15'd0, m_run});
        chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic r_ss;
        logic r_clr;

        // 1. Reset values
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_digits",   digits,            16'hFFF0);
        chk("rst_running",  {15'd0, running},  16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);

        // 2. Start and hold high: one tick every 4 clk, count 10 after 40 clk
        step(1'b1, 1'b0);
        chk("t2_running", {15'd0, running}, 16'd1);
        repeat (40) step(1'b1, 1'b0);
        chk("t2_count10", digits, 16'hFF10);
        repeat (3) step(1'b1, 1'b0);

        // 3. Pause preserves the partial prescaler period
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("t3_stopped", {15'd0, running}, 16'd0);
        repeat (20) step(1'b0, 1'b0);
        chk("t3_hold", digits, 16'hFFF0);
        step(1'b1, 1'b0);
        chk("t3_restart0", digits, 16'hFFF0);
        step(1'b1, 1'b0);
        chk("t3_restart1", digits, 16'hFFF0);
        step(1'b1, 1'b0);
        chk("t3_first_tick", digits, 16'hFFF1);

        // 4. Run to 9999, then wrap to 0 with sticky overflow
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n = 0;
        while (m_cnt != 9999 && n < 50000) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("t4_9999", digits, 16'h9999);
        chk("t4_no_ovf_yet", {15'd0, overflow}, 16'd0);
        n = 0;
        while (!m_ovf && n < 10) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("t4_wrap_digits",  digits,            16'hFFF0);
        chk("t4_wrap_ovf",     {15'd0, overflow}, 16'd1);
        chk("t4_wrap_running", {15'd0, running},  16'd1);
        repeat (6) step(1'b1, 1'b0);
        chk("t4_ovf_sticky", {15'd0, overflow}, 16'd1);
        step(1'b1, 1'b1);
        chk("t4_clr_ovf",     {15'd0, overflow}, 16'd0);
        chk("t4_clr_running", {15'd0, running},  16'd0);

        // 5. clear and a start_stop edge together while stopped at 0042
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n = 0;
        while (m_cnt != 42 && n < 1000) begin
            step(1'b0, 1'b0);
            n++;
        end
        step(1'b1, 1'b0);
        chk("t5_at42", digits, 16'hFF42);
        chk("t5_stopped", {15'd0, running}, 16'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("t5_clr_digits",  digits,           16'hFFF0);
        chk("t5_clr_running", {15'd0, running}, 16'd0);
        repeat (8) step(1'b1, 1'b0);
        chk("t5_no_ticks", digits, 16'hFFF0);

        // 6. Asynchronous reset between clock edges at count 0123
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n = 0;
        while (m_cnt != 123 && n < 2000) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t6_at123", digits, 16'hF123);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_digits",   digits,            16'hFFF0);
        chk("t6_async_running",  {15'd0, running},  16'd0);
        chk("t6_async_overflow", {15'd0, overflow}, 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;

        // Random start_stop levels and occasional clears
        r_ss = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) r_ss = ~r_ss;
            r_clr = ($urandom_range(0, 99) == 0);
            step(r_ss, r_clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
